sha256_job_scheduler: RTL and testbench

//  Shares one simplified SHA-256 core between NUM_REQ requesters.

---
 rtl/sha256_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_sha256_job_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_job_scheduler.sv
// rtl/sha256_job_scheduler.sv - round-robin job scheduler sharing one SHA-256 core among requesters
module sha256_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_msg_addr,
    input  logic [16*NUM_REQ-1:0]   req_out_addr,
    output logic [NUM_REQ-1:0]      req_accept,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_err,
    output logic                    core_start,
    output logic [15:0]             core_msg_addr,
    output logic [15:0]             core_out_addr,
    input  logic                    core_done,
    output logic                    busy,
    output logic                    hung,
    output logic [2:0]              owner,
    output logic [15:0]             jobs_done
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_RUN, S_FINISH, S_HUNG
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2:0]           rr;
    logic [TW-1:0]        timer;
    logic                 err;
    logic                 found;
    logic [2:0]           pick;
    logic [15:0]          sel_msg;
    logic [15:0]          sel_out;
    logic                 timeout_hit;
    logic [NUM_REQ-1:0]   pick_mask;
    logic [NUM_REQ-1:0]   owner_mask;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign pick_mask   = NUM_REQ'(1) << pick;
    assign owner_mask  = NUM_REQ'(1) << owner;

    // Round-robin arbitration: first valid at or after rr, else wrap to the lowest valid
    always_comb begin
        found   = 1'b0;
        pick    = 3'd0;
        sel_msg = 16'd0;
        sel_out = 16'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (3'(i) >= rr)) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == pick) begin
                sel_msg = req_msg_addr[16*i +: 16];
                sel_out = req_out_addr[16*i +: 16];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a stuck core cannot be aborted, so HUNG is terminal until reset
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (found) state_next = S_ISSUE;
            S_ISSUE:  state_next = S_SETTLE;
            S_SETTLE: state_next = S_RUN;
            S_RUN:    if (core_done || timeout_hit) state_next = S_FINISH;
            S_FINISH: state_next = err ? S_HUNG : S_IDLE;
            S_HUNG:   state_next = S_HUNG;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath; pulses are aligned with the state they belong to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_accept    <= '0;
            req_done      <= '0;
            req_err       <= '0;
            core_start    <= 1'b0;
            core_msg_addr <= 16'd0;
            core_out_addr <= 16'd0;
            busy          <= 1'b0;
            hung          <= 1'b0;
            owner         <= 3'd0;
            jobs_done     <= 16'd0;
            rr            <= 3'd0;
            timer         <= '0;
            err           <= 1'b0;
        end else begin
            req_accept <= '0;
            req_done   <= '0;
            req_err    <= '0;
            core_start <= (state_next == S_ISSUE);
            busy       <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner         <= pick;
                        core_msg_addr <= sel_msg;
                        core_out_addr <= sel_out;
                        req_accept    <= pick_mask;
                        rr            <= (pick == 3'(NUM_REQ - 1)) ? 3'd0 : pick + 3'd1;
                    end
                end
                S_SETTLE: begin
                    timer <= '0;
                end
                S_RUN: begin
                    if (core_done) begin
                        err       <= 1'b0;
                        req_done  <= owner_mask;
                        jobs_done <= jobs_done + 16'd1;
                    end else if (timeout_hit) begin
                        err      <= 1'b1;
                        req_done <= owner_mask;
                        req_err  <= owner_mask;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (err) hung <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// tb/tb_sha256_job_scheduler.sv - scoreboard bench for sha256_job_scheduler
module tb_sha256_job_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_msg_addr = '0;
    logic [16*N-1:0] req_out_addr = '0;
    logic [N-1:0]    req_accept, req_done, req_err;
    logic            core_start;
    logic [15:0]     core_msg_addr, core_out_addr;
    logic            core_done = 1'b0;
    logic            busy, hung;
    logic [2:0]      owner;
    logic [15:0]     jobs_done;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int cur = 0;
    int acc_cnt = 0, done_cnt = 0, start_cnt = 0, cyc = 0;
    int acc_cycle = 0, done_cycle = 0, start_cycle = 0, prev_start_cycle = 0;
    bit exp_err = 1'b0;
    int model_rr = 0;
    logic [15:0] msg_tab[N];
    logic [15:0] out_tab[N];
    bit core_enable = 1'b1;
    bit core_stuck = 1'b0;
    int core_lat = 3;
    bit core_running = 1'b0;
    int core_cnt = 0;

    always #5 clk = ~clk;

    sha256_job_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
        .req_msg_addr(req_msg_addr), .req_out_addr(req_out_addr),
        .req_accept(req_accept), .req_done(req_done), .req_err(req_err),
        .core_start(core_start), .core_msg_addr(core_msg_addr), .core_out_addr(core_out_addr),
        .core_done(core_done), .busy(busy), .hung(hung), .owner(owner), .jobs_done(jobs_done)
    );

    // Simple core model: done rises core_lat cycles after start and stays high until next start
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                core_done = core_stuck;
                core_running = 1'b0;
            end else if (core_stuck) begin
                core_done = 1'b1;
            end else if (core_start === 1'b1) begin
                core_done = 1'b0;
                core_running = 1'b1;
                core_cnt = core_lat;
            end else if (core_running && core_enable) begin
                if (core_cnt <= 1) begin
                    core_done = 1'b1;
                    core_running = 1'b0;
                end else begin
                    core_cnt--;
                end
            end
        end
    end

    // Scoreboard monitor: grants popped from exp_q, addresses and completions checked
    initial begin
        int e;
        logic [N-1:0] m, em;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (req_accept !== '0) begin
                    acc_cnt++;
                    acc_cycle = cyc;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL accept_unexpected got=%b want=none", req_accept);
                    end else begin
                        e = exp_q.pop_front();
                        m = N'(1) << e;
                        if (req_accept !== m || owner !== 3'(e)) begin
                            bad++;
                            $display("FAIL grant got=%b/%0d want=%b/%0d", req_accept, owner, m, e);
                        end
                        cur = e;
                    end
                end
                if (core_start === 1'b1) begin
                    start_cnt++;
                    prev_start_cycle = start_cycle;
                    start_cycle = cyc;
                    total++;
                    if (core_msg_addr !== msg_tab[cur] || core_out_addr !== out_tab[cur]) begin
                        bad++;
                        $display("FAIL core_addr got=%h/%h want=%h/%h", core_msg_addr, core_out_addr,
                                 msg_tab[cur], out_tab[cur]);
                    end
                end
                if (req_done !== '0) begin
                    done_cnt++;
                    done_cycle = cyc;
                    total++;
                    m = N'(1) << cur;
                    em = exp_err ? m : '0;
                    if (req_done !== m || req_err !== em) begin
                        bad++;
                        $display("FAIL done got=%b/%b want=%b/%b", req_done, req_err, m, em);
                    end
                end
            end
        end
    end

    task automatic predict(input logic [N-1:0] pat, input int n);
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (model_rr + k) % N;
                if (pat[idx]) begin
                    exp_q.push_back(idx);
                    model_rr = (idx + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        exp_err = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_rr = 0;
        acc_cnt = 0;
        done_cnt = 0;
        start_cnt = 0;
        @(negedge clk);
        #1;
    endtask

    task automatic run_jobs(input logic [N-1:0] pat, input int n);
        int a0, d0, b;
        predict(pat, n);
        a0 = acc_cnt;
        d0 = done_cnt;
        req_valid = pat;
        b = 0;
        while (acc_cnt < a0 + n && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
        end
        req_valid = '0;
        b = 0;
        while (done_cnt < d0 + n && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if ({req_accept, req_done, req_err, core_start, busy, hung, owner} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0", {req_accept, req_done, req_err, core_start, busy, hung, owner});
        end
        total++;
        if ({core_msg_addr, core_out_addr} !== 32'd0) begin
            bad++;
            $display("FAIL reset_addr got=%h want=0", {core_msg_addr, core_out_addr});
        end
        do_reset();
        total++;
        if (jobs_done !== 16'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_jobs got=%0d/%b want=0/0", jobs_done, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        core_lat = 3;
        run_jobs(4'b0100, 1);
        total++;
        if (acc_cnt !== 1 || done_cnt !== 1) begin
            bad++;
            $display("FAIL single_counts got=%0d/%0d want=1/1", acc_cnt, done_cnt);
        end
        total++;
        if (start_cnt !== 1) begin
            bad++;
            $display("FAIL single_starts got=%0d want=1", start_cnt);
        end
        total++;
        if (jobs_done !== 16'd1) begin
            bad++;
            $display("FAIL single_jobs got=%0d want=1", jobs_done);
        end
        total++;
        if (core_msg_addr !== 16'h0100 || core_out_addr !== 16'h0200) begin
            bad++;
            $display("FAIL single_addr got=%h/%h want=0100/0200", core_msg_addr, core_out_addr);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_pair();
        do_reset();
        core_lat = 2;
        run_jobs(4'b1010, 4);
        total++;
        if (start_cnt !== 4 || done_cnt !== 4) begin
            bad++;
            $display("FAIL pair_counts got=%0d/%0d want=4/4", start_cnt, done_cnt);
        end
        total++;
        if (exp_q.size() !== 0 || jobs_done !== 16'd4) begin
            bad++;
            $display("FAIL pair_jobs got=%0d/%0d want=0/4", exp_q.size(), jobs_done);
        end
    endtask

    task automatic test_all();
        do_reset();
        core_lat = 4;
        run_jobs(4'b1111, 8);
        total++;
        if (jobs_done !== 16'd8) begin
            bad++;
            $display("FAIL all_jobs got=%0d want=8", jobs_done);
        end
        total++;
        if (start_cnt !== 8 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL all_starts got=%0d/%0d want=8/0", start_cnt, exp_q.size());
        end
    endtask

    task automatic test_back_to_back_stale();
        do_reset();
        core_stuck = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        run_jobs(4'b0001, 2);
        total++;
        if (done_cycle - acc_cycle !== 3) begin
            bad++;
            $display("FAIL stale_latency got=%0d want=3", done_cycle - acc_cycle);
        end
        total++;
        if (start_cycle - prev_start_cycle !== 5) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=5", start_cycle - prev_start_cycle);
        end
        total++;
        if (jobs_done !== 16'd2) begin
            bad++;
            $display("FAIL stale_jobs got=%0d want=2", jobs_done);
        end
        core_stuck = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int b, d0;
        do_reset();
        core_enable = 1'b0;
        predict(4'b0100, 1);
        req_valid = 4'b0100;
        b = 0;
        while (acc_cnt < 1 && b < 100) begin
            @(negedge clk);
            #1;
            b++;
        end
        req_valid = '0;
        repeat (5) @(negedge clk);
        #1;
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        total++;
        if ({req_accept, req_done, req_err, core_start, busy, hung, owner, core_msg_addr, core_out_addr, jobs_done} !== '0) begin
            bad++;
            $display("FAIL midrun_reset got=%b/%b/%0d/%h want=all0", busy, core_start, owner, core_msg_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_rr = 0;
        exp_q.delete();
        core_enable = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (done_cnt !== d0) begin
            bad++;
            $display("FAIL midrun_nodone got=%0d want=%0d", done_cnt, d0);
        end
        run_jobs(4'b1111, 1);
        total++;
        if (owner !== 3'd0 || jobs_done !== 16'd1) begin
            bad++;
            $display("FAIL midrun_regrant got=%0d/%0d want=0/1", owner, jobs_done);
        end
    endtask

    task automatic test_timeout();
        int a0;
        do_reset();
        core_enable = 1'b0;
        exp_err = 1'b1;
        predict(4'b1111, 1);
        req_valid = 4'b1111;
        a0 = 0;
        while (done_cnt < 1 && a0 < 200) begin
            @(negedge clk);
            #1;
            a0++;
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL timeout_done got=%0d want=1", done_cnt);
        end
        total++;
        if (done_cycle - acc_cycle !== TO + 2) begin
            bad++;
            $display("FAIL timeout_len got=%0d want=%0d", done_cycle - acc_cycle, TO + 2);
        end
        @(negedge clk);
        #1;
        total++;
        if (hung !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hung got=%b/%b want=1/1", hung, busy);
        end
        a0 = acc_cnt;
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (acc_cnt !== a0 || start_cnt !== 1) begin
            bad++;
            $display("FAIL hung_noaccept got=%0d/%0d want=%0d/1", acc_cnt, start_cnt, a0);
        end
        total++;
        if (jobs_done !== 16'd0 || hung !== 1'b1) begin
            bad++;
            $display("FAIL hung_state got=%0d/%b want=0/1", jobs_done, hung);
        end
        req_valid = '0;
        core_enable = 1'b1;
        exp_err = 1'b0;
    endtask

    initial begin
        msg_tab[0] = 16'hA000; out_tab[0] = 16'hA800;
        msg_tab[1] = 16'hB100; out_tab[1] = 16'hB900;
        msg_tab[2] = 16'h0100; out_tab[2] = 16'h0200;
        msg_tab[3] = 16'hD300; out_tab[3] = 16'hDB00;
        for (int i = 0; i < N; i++) begin
            req_msg_addr[16*i +: 16] = msg_tab[i];
            req_out_addr[16*i +: 16] = out_tab[i];
        end
        test_reset();
        test_single();
        test_pair();
        test_all();
        test_back_to_back_stale();
        test_reset_mid_run();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
